// File: rtl/out_vc_state_tracker.sv
// Per-output-port tracker of downstream VC state and credits. An output VC is
// offered for reallocation only after its tail has left and every downstream slot is credited.
module out_vc_state_tracker #(
  parameter int unsigned CN        = 5,
  parameter int unsigned BUF_DEPTH = 4,
  localparam int unsigned CW       = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CN-1:0]    outVCAvailableReset,
  input  logic             flitValid,
  input  logic [CN-1:0]    flitVC,
  input  logic             flitTail,
  input  logic [CN-1:0]    creditReturn,
  output logic [CN-1:0]    outVCAvailable,
  output logic [CN-1:0]    outVCHasCredit,
  output logic [CN*CW-1:0] creditCount,
  output logic             protocolError
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } vc_state_e;

  localparam logic [CW-1:0] CntFull = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  vc_state_e     state_q [CN];
  vc_state_e     state_d [CN];
  logic [CW-1:0] count_q [CN];
  logic [CW-1:0] count_d [CN];
  logic          err_q, err_d;

  logic          flit_ok, flit_bad;
  logic [CN-1:0] send_vec;

  // A malformed flitVC is dropped entirely so no VC sees a partial send.
  assign flit_ok  = flitValid & $onehot(flitVC);
  assign flit_bad = flitValid & ~$onehot(flitVC);
  assign send_vec = flit_ok ? flitVC : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CN; i++) begin
        state_q[i] <= StIdle;
        count_q[i] <= CntFull;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < CN; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    err_d = err_q | flit_bad;
    for (int i = 0; i < CN; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];

      // Saturate on underflow/overflow; a paired send+credit is a no-op.
      if (send_vec[i] && !creditReturn[i]) begin
        if (count_q[i] == '0) err_d = 1'b1;
        else                  count_d[i] = count_q[i] - CntOne;
      end else if (!send_vec[i] && creditReturn[i]) begin
        if (count_q[i] == CntFull) err_d = 1'b1;
        else                       count_d[i] = count_q[i] + CntOne;
      end

      case (state_q[i])
        StIdle: begin
          if (outVCAvailableReset[i]) state_d[i] = StActive;
          if (send_vec[i])            err_d = 1'b1;
        end
        StActive: begin
          if (send_vec[i] && flitTail) state_d[i] = StDrain;
          if (outVCAvailableReset[i])  err_d = 1'b1;
        end
        StDrain: begin
          // Uses the registered count, so a drained VC spends at least one cycle here.
          if (count_q[i] == CntFull)                 state_d[i] = StIdle;
          if (send_vec[i] || outVCAvailableReset[i]) err_d = 1'b1;
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    outVCAvailable = '0;
    outVCHasCredit = '0;
    creditCount    = '0;
    for (int i = 0; i < CN; i++) begin
      outVCAvailable[i]           = (state_q[i] == StIdle);
      outVCHasCredit[i]           = (state_q[i] == StActive) && (count_q[i] != '0);
      creditCount[i*CW +: CW]     = count_q[i];
    end
    protocolError = err_q;
  end

endmodule

// File: tb/tb_out_vc_state_tracker.sv
// Directed bench for out_vc_state_tracker: allocation, credit flow, drain release,
// protocol violations and mid-packet reset.
module tb_out_vc_state_tracker;

  localparam int CN = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CN-1:0] outVCAvailableReset;
  logic          flitValid;
  logic [CN-1:0] flitVC;
  logic          flitTail;
  logic [CN-1:0] creditReturn;
  logic [CN-1:0] outVCAvailable;
  logic [CN-1:0] outVCHasCredit;
  logic [CN*CW-1:0] creditCount;
  logic          protocolError;

  int checks   = 0;
  int failures = 0;

  out_vc_state_tracker #(.CN(5), .BUF_DEPTH(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .outVCAvailableReset (outVCAvailableReset),
    .flitValid           (flitValid),
    .flitVC              (flitVC),
    .flitTail            (flitTail),
    .creditReturn        (creditReturn),
    .outVCAvailable      (outVCAvailable),
    .outVCHasCredit      (outVCHasCredit),
    .creditCount         (creditCount),
    .protocolError       (protocolError)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cnt(input int i);
    return creditCount[i*CW +: CW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [CN-1:0] vc, input logic tail);
    flitValid = 1'b1;
    flitVC    = vc;
    flitTail  = tail;
    tick();
    flitValid = 1'b0;
    flitVC    = '0;
    flitTail  = 1'b0;
  endtask

  task automatic alloc(input logic [CN-1:0] vcs);
    outVCAvailableReset = vcs;
    tick();
    outVCAvailableReset = '0;
  endtask

  initial begin
    rst = 1'b1;
    outVCAvailableReset = '0;
    flitValid = 1'b0;
    flitVC = '0;
    flitTail = 1'b0;
    creditReturn = '0;

    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("reset_avail", outVCAvailable, 5'b11111);
    chk("reset_hascredit", outVCHasCredit, 5'b00000);
    for (int i = 0; i < CN; i++) chk($sformatf("reset_count%0d", i), cnt(i), 4);
    chk("reset_err", protocolError, 1'b0);

    // Allocate VC2 and drain its credits with body flits
    alloc(5'b00100);
    chk("alloc2_avail", outVCAvailable, 5'b11011);
    chk("alloc2_hascredit", outVCHasCredit, 5'b00100);
    for (int k = 1; k <= 4; k++) begin
      send(5'b00100, 1'b0);
      chk($sformatf("vc2_count_k%0d", k), cnt(2), 4 - k);
      chk($sformatf("vc2_hascredit_k%0d", k), outVCHasCredit[2], (k < 4) ? 1'b1 : 1'b0);
    end
    chk("vc2_err", protocolError, 1'b0);

    // Single-flit packet on VC0, credit returned two cycles later
    alloc(5'b00001);
    chk("alloc0_avail", outVCAvailable, 5'b11010);
    send(5'b00001, 1'b1);
    chk("vc0_count_after_tail", cnt(0), 3);
    chk("vc0_avail_drain1", outVCAvailable[0], 1'b0);
    chk("vc0_hascredit_drain", outVCHasCredit[0], 1'b0);
    tick();
    chk("vc0_avail_drain2", outVCAvailable[0], 1'b0);
    creditReturn = 5'b00001;
    tick();
    creditReturn = '0;
    chk("vc0_count_full", cnt(0), 4);
    chk("vc0_avail_drain3", outVCAvailable[0], 1'b0);
    tick();
    chk("vc0_avail_released", outVCAvailable[0], 1'b1);
    chk("vc0_err", protocolError, 1'b0);

    // VC1 down to 2, then paired send+credit
    alloc(5'b00010);
    send(5'b00010, 1'b0);
    send(5'b00010, 1'b0);
    chk("vc1_count2", cnt(1), 2);
    creditReturn = 5'b00010;
    send(5'b00010, 1'b0);
    creditReturn = '0;
    chk("vc1_send_credit_same", cnt(1), 2);

    // VC3 to 2, VC4 to 0, then independent updates in one cycle
    alloc(5'b11000);
    send(5'b01000, 1'b0);
    send(5'b01000, 1'b0);
    for (int k = 0; k < 4; k++) send(5'b10000, 1'b0);
    chk("vc3_count2", cnt(3), 2);
    chk("vc4_count0", cnt(4), 0);
    creditReturn = 5'b11000;
    send(5'b00010, 1'b0);
    creditReturn = '0;
    chk("indep_vc1", cnt(1), 1);
    chk("indep_vc3", cnt(3), 3);
    chk("indep_vc4", cnt(4), 1);
    chk("indep_vc2", cnt(2), 0);
    chk("indep_vc0", cnt(0), 4);
    chk("indep_err", protocolError, 1'b0);
    send(5'b10000, 1'b0);
    chk("vc4_back_to0", cnt(4), 0);
    chk("vc4_err_legal", protocolError, 1'b0);

    // Violation: send on VC4 with no credit
    send(5'b10000, 1'b0);
    chk("viol_underflow_count", cnt(4), 0);
    chk("viol_underflow_err", protocolError, 1'b1);
    tick();
    chk("viol_err_sticky", protocolError, 1'b1);

    // Violation: allocate already-ACTIVE VC3
    alloc(5'b01000);
    chk("viol_realloc_avail", outVCAvailable, 5'b00001);
    chk("viol_realloc_hascredit", outVCHasCredit, 5'b01010);
    chk("viol_realloc_count3", cnt(3), 3);

    // Violation: non-one-hot flitVC
    send(5'b00011, 1'b1);
    chk("viol_multihot_vc0", cnt(0), 4);
    chk("viol_multihot_vc1", cnt(1), 1);
    chk("viol_multihot_hascredit", outVCHasCredit, 5'b01010);
    chk("viol_multihot_avail", outVCAvailable, 5'b00001);

    // Mid-packet reset with VC1 ACTIVE at count 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_vc1_count", cnt(1), 4);
    chk("rst_avail", outVCAvailable, 5'b11111);
    chk("rst_hascredit", outVCHasCredit, 5'b00000);
    chk("rst_err", protocolError, 1'b0);

    // Tail with paired credit at full count still passes through DRAIN for one cycle
    alloc(5'b00001);
    creditReturn = 5'b00001;
    send(5'b00001, 1'b1);
    creditReturn = '0;
    chk("fulltail_count", cnt(0), 4);
    chk("fulltail_avail_drain", outVCAvailable[0], 1'b0);
    tick();
    chk("fulltail_avail_released", outVCAvailable[0], 1'b1);
    chk("fulltail_err", protocolError, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
